// File: rtl/axis_chk_pkg.sv
// Shared types, constants and helpers for the AXI-stream LFSR checker and its
// reference generator.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    DONE = 2'd3
  } chk_state_e;

  localparam int LFSR_W = 64;
  // Feedback taps x^64 + x^63 + x^61 + x^60 + 1 (maximal length).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam int SAT_W = 32;

  // Counters are evaluated at a common width and never wrap past max_val.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    if (val >= max_val) begin
      return val;
    end else begin
      return val + 32'd1;
    end
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream bundle shared by the LFSR traffic source and checker.
interface axis_if #(
  parameter int DATAW = 64
) ();

  logic [DATAW-1:0] data;
  logic             vld;
  logic             last;
  logic             rdy;

  modport in  (input data, input vld, input last, output rdy);
  modport out (output data, output vld, output last, input rdy);

endinterface

// File: rtl/lfsr_64bit.sv
// Free-running 64-bit Fibonacci LFSR; reloads SEED while s_rst_n is low.
module lfsr_64bit
  import axis_chk_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 64'hFEDC_BA98_7654_3210
) (
  input  logic              clk,
  input  logic              s_rst_n,
  output logic [LFSR_W-1:0] lfsr_q
);

  logic [LFSR_W-1:0] state_r;

  // Reload on reset, otherwise advance one step every clock.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_r <= SEED;
    end else begin
      state_r <= lfsr_next(state_r);
    end
  end

  assign lfsr_q = state_r;

endmodule

// File: rtl/axis_chk.sv
// AXI-stream sink that checks LFSR payload and every-N-th-beat framing,
// keeping saturating status counters and a sticky pass/fail result.
module axis_chk
  import axis_chk_pkg::*;
#(
  parameter int                N           = 16,
  parameter int                DATAW       = 64,
  parameter logic [LFSR_W-1:0] SEED        = 64'hFEDC_BA98_7654_3210,
  parameter int                NUM_FRAMES  = 8,
  parameter logic              STOP_ON_ERR = 1'b0,
  parameter int                CNTW        = 16
) (
  input  logic            clk,
  input  logic            s_rst,
  axis_if.in              lfsr_in,
  input  logic            rdy_en,
  output logic [CNTW-1:0] beat_cnt,
  output logic [CNTW-1:0] frame_cnt,
  output logic [CNTW-1:0] data_err_cnt,
  output logic [CNTW-1:0] frm_err_cnt,
  output logic            done,
  output logic            pass
);

  localparam int              IDX_W      = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [SAT_W-1:0] CNT_MAX   = SAT_W'((64'd1 << CNTW) - 64'd1);
  localparam logic [SAT_W-1:0] FRAMES_TGT = SAT_W'(NUM_FRAMES);

  chk_state_e        state_r;
  chk_state_e        state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic              rdy_r;
  logic              s_rst_n_s;
  logic [LFSR_W-1:0] ref_s;
  logic              accept_s;
  logic              last_exp_s;
  logic              data_err_s;
  logic              frm_err_s;
  logic              frame_end_s;
  logic [SAT_W-1:0]  frame_nxt_s;

  assign s_rst_n_s = ~s_rst;

  // The reference must see exactly the same reset release as the source.
  lfsr_64bit #(
    .SEED (SEED)
  ) u_ref (
    .clk     (clk),
    .s_rst_n (s_rst_n_s),
    .lfsr_q  (ref_s)
  );

  assign lfsr_in.rdy = rdy_r;

  // Per-beat qualification, payload/framing checks and next frame count.
  always_comb begin
    accept_s    = lfsr_in.vld & rdy_r & (state_r == RUN);
    last_exp_s  = (idx_r == IDX_LAST);
    data_err_s  = accept_s & (lfsr_in.data[DATAW-1:0] != ref_s[DATAW-1:0]);
    frm_err_s   = accept_s & (lfsr_in.last != last_exp_s);
    frame_end_s = accept_s & last_exp_s;
    if (frame_end_s) begin
      frame_nxt_s = sat_inc(SAT_W'(frame_cnt), CNT_MAX);
    end else begin
      frame_nxt_s = SAT_W'(frame_cnt);
    end
  end

  // Next-state decode; completion takes priority over an error on the final beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (frame_end_s && (frame_nxt_s >= FRAMES_TGT)) begin
          state_nxt_s = DONE;
        end else if (STOP_ON_ERR && (data_err_s || frm_err_s)) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      DONE: begin
        state_nxt_s = DONE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Checker state, handshake, beat index and saturating status counters.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_r      <= IDLE;
      rdy_r        <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
      beat_cnt     <= {CNTW{1'b0}};
      frame_cnt    <= {CNTW{1'b0}};
      data_err_cnt <= {CNTW{1'b0}};
      frm_err_cnt  <= {CNTW{1'b0}};
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rdy_r   <= (state_nxt_s == RUN) & rdy_en;
      done    <= (state_nxt_s == HALT) | (state_nxt_s == DONE);
      pass    <= done & (data_err_cnt == {CNTW{1'b0}}) & (frm_err_cnt == {CNTW{1'b0}});
      if (accept_s) begin
        beat_cnt  <= CNTW'(sat_inc(SAT_W'(beat_cnt), CNT_MAX));
        frame_cnt <= CNTW'(frame_nxt_s);
        // Frame boundaries follow the local index, not the received last.
        if (last_exp_s) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1'b1);
        end
        if (data_err_s) begin
          data_err_cnt <= CNTW'(sat_inc(SAT_W'(data_err_cnt), CNT_MAX));
        end
        if (frm_err_s) begin
          frm_err_cnt <= CNTW'(sat_inc(SAT_W'(frm_err_cnt), CNT_MAX));
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_chk.sv
// Directed bench for axis_chk: the bench plays the LFSR source for three
// checker instances (free-running, stop-on-error, 4-bit counters).
`timescale 1ns/1ps
module tb_axis_chk;

  localparam int          N          = 16;
  localparam int          DATAW      = 64;
  localparam logic [63:0] SEED       = 64'hFEDCBA9876543210;
  // SEED shifted left once; the feedback bit for SEED is 1^1^1^1 = 0.
  localparam logic [63:0] SEED_STEP1 = 64'hFDB97530ECA86420;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst_a    [3];
  logic        vld_a    [3];
  logic        last_a   [3];
  logic        flip_a   [3];
  logic        rdy_en_a [3];
  logic [63:0] src_q    [3];

  logic        rdy_a   [3];
  logic        done_a  [3];
  logic        pass_a  [3];
  logic [15:0] beat_a  [3];
  logic [15:0] frame_a [3];
  logic [15:0] derr_a  [3];
  logic [15:0] ferr_a  [3];

  logic [15:0] m_beat, m_frame, m_derr, m_ferr;
  logic [15:0] h_beat, h_frame, h_derr, h_ferr;
  logic [3:0]  s_beat, s_frame, s_derr, s_ferr;
  logic        m_done, m_pass, h_done, h_pass, s_done, s_pass;

  function automatic logic [63:0] ref_step(input logic [63:0] q);
    logic fb;
    fb = q[63] ^ q[62] ^ q[60] ^ q[59];
    return {q[62:0], fb};
  endfunction

  // Source LFSR per channel, reset together with its checker.
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      src_q[c] <= rst_a[c] ? SEED : ref_step(src_q[c]);
    end
  end

  axis_if #(.DATAW(DATAW)) if_m ();
  axis_if #(.DATAW(DATAW)) if_h ();
  axis_if #(.DATAW(DATAW)) if_s ();

  assign if_m.data = src_q[0] ^ {63'd0, flip_a[0]};
  assign if_m.vld  = vld_a[0];
  assign if_m.last = last_a[0];
  assign if_h.data = src_q[1] ^ {63'd0, flip_a[1]};
  assign if_h.vld  = vld_a[1];
  assign if_h.last = last_a[1];
  assign if_s.data = src_q[2] ^ {63'd0, flip_a[2]};
  assign if_s.vld  = vld_a[2];
  assign if_s.last = last_a[2];

  axis_chk #(.N(N), .DATAW(DATAW), .SEED(SEED), .NUM_FRAMES(8), .STOP_ON_ERR(1'b0), .CNTW(16)) u_main (
    .clk(clk), .s_rst(rst_a[0]), .lfsr_in(if_m), .rdy_en(rdy_en_a[0]),
    .beat_cnt(m_beat), .frame_cnt(m_frame), .data_err_cnt(m_derr), .frm_err_cnt(m_ferr),
    .done(m_done), .pass(m_pass));

  axis_chk #(.N(N), .DATAW(DATAW), .SEED(SEED), .NUM_FRAMES(8), .STOP_ON_ERR(1'b1), .CNTW(16)) u_halt (
    .clk(clk), .s_rst(rst_a[1]), .lfsr_in(if_h), .rdy_en(rdy_en_a[1]),
    .beat_cnt(h_beat), .frame_cnt(h_frame), .data_err_cnt(h_derr), .frm_err_cnt(h_ferr),
    .done(h_done), .pass(h_pass));

  axis_chk #(.N(N), .DATAW(DATAW), .SEED(SEED), .NUM_FRAMES(2), .STOP_ON_ERR(1'b0), .CNTW(4)) u_sat (
    .clk(clk), .s_rst(rst_a[2]), .lfsr_in(if_s), .rdy_en(rdy_en_a[2]),
    .beat_cnt(s_beat), .frame_cnt(s_frame), .data_err_cnt(s_derr), .frm_err_cnt(s_ferr),
    .done(s_done), .pass(s_pass));

  // Gather per-instance status into channel-indexed views.
  always_comb begin
    rdy_a[0] = if_m.rdy;  rdy_a[1] = if_h.rdy;  rdy_a[2] = if_s.rdy;
    done_a[0] = m_done;   done_a[1] = h_done;   done_a[2] = s_done;
    pass_a[0] = m_pass;   pass_a[1] = h_pass;   pass_a[2] = s_pass;
    beat_a[0] = m_beat;   beat_a[1] = h_beat;   beat_a[2] = {12'd0, s_beat};
    frame_a[0] = m_frame; frame_a[1] = h_frame; frame_a[2] = {12'd0, s_frame};
    derr_a[0] = m_derr;   derr_a[1] = h_derr;   derr_a[2] = {12'd0, s_derr};
    ferr_a[0] = m_ferr;   ferr_a[1] = h_ferr;   ferr_a[2] = {12'd0, s_ferr};
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_status(input int ch, input string tag, input int beat, input int frame,
                              input int derr, input int ferr, input logic done, input logic pass);
    chk_eq({tag, ".beat_cnt"},     64'(beat_a[ch]),  64'(beat));
    chk_eq({tag, ".frame_cnt"},    64'(frame_a[ch]), 64'(frame));
    chk_eq({tag, ".data_err_cnt"}, 64'(derr_a[ch]),  64'(derr));
    chk_eq({tag, ".frm_err_cnt"},  64'(ferr_a[ch]),  64'(ferr));
    chk_eq({tag, ".done"},         64'(done_a[ch]),  64'(done));
    chk_eq({tag, ".pass"},         64'(pass_a[ch]),  64'(pass));
  endtask

  task automatic reset_ch(input int ch, input int ncyc, input string tag);
    rst_a[ch]  = 1'b1;
    vld_a[ch]  = 1'b0;
    last_a[ch] = 1'b0;
    flip_a[ch] = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    check_status(ch, tag, 0, 0, 0, 0, 1'b0, 1'b0);
    chk_eq({tag, ".rdy"}, 64'(rdy_a[ch]), 64'd0);
    rst_a[ch] = 1'b0;
  endtask

  // Offer beats with vld held high; last/flip follow the bench's own beat count.
  task automatic run_stream(input int ch, input int nbeats, input int max_cyc, input int flip_beat,
                            input int bad_last, input bit flip_all, input bit rand_rdy,
                            input bit expect_halt, output int sent, output logic [63:0] first_d);
    bit hs;
    sent    = 0;
    first_d = 64'd0;
    vld_a[ch] = 1'b1;
    for (int cyc = 0; cyc < max_cyc && sent < nbeats; cyc++) begin
      last_a[ch] = ((sent % N) == N - 1) || (sent == bad_last);
      flip_a[ch] = flip_all || (sent == flip_beat);
      if (rand_rdy) rdy_en_a[ch] = 1'($urandom_range(1, 0));
      hs = vld_a[ch] & rdy_a[ch];
      if (hs && sent == 0) first_d = src_q[ch] ^ {63'd0, flip_a[ch]};
      @(posedge clk);
      #1;
      if (hs) begin
        sent++;
        if (expect_halt && sent == flip_beat + 1)
          chk_eq("halt.rdy_drop", 64'(rdy_a[ch]), 64'd0);
      end
      if (rand_rdy) chk_eq("rand.beat_track", 64'(beat_a[ch]), 64'(sent));
    end
    vld_a[ch]    = 1'b0;
    last_a[ch]   = 1'b0;
    flip_a[ch]   = 1'b0;
    rdy_en_a[ch] = 1'b1;
  endtask

  initial begin
    int          sent;
    logic [63:0] fd;
    for (int c = 0; c < 3; c++) begin
      rst_a[c]    = 1'b1;
      vld_a[c]    = 1'b0;
      last_a[c]   = 1'b0;
      flip_a[c]   = 1'b0;
      rdy_en_a[c] = 1'b1;
    end

    // Clean stream: 8 frames of 16 beats.
    reset_ch(0, 2, "clean.rst");
    run_stream(0, 128, 400, -1, -1, 1'b0, 1'b0, 1'b0, sent, fd);
    chk_eq("clean.sent", 64'(sent), 64'd128);
    chk_eq("clean.first_beat", fd, SEED_STEP1);
    vld_a[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vld_a[0] = 1'b0;
    check_status(0, "clean", 128, 8, 0, 0, 1'b1, 1'b1);
    chk_eq("clean.rdy", 64'(rdy_a[0]), 64'd0);

    // One payload bit flipped on beat 5.
    reset_ch(0, 2, "flip.rst");
    run_stream(0, 128, 400, 5, -1, 1'b0, 1'b0, 1'b0, sent, fd);
    chk_eq("flip.sent", 64'(sent), 64'd128);
    repeat (3) @(posedge clk);
    #1;
    check_status(0, "flip", 128, 8, 1, 0, 1'b1, 1'b0);

    // Spurious last on beat 3 of frame 0.
    reset_ch(0, 2, "last.rst");
    run_stream(0, 128, 400, -1, 3, 1'b0, 1'b0, 1'b0, sent, fd);
    chk_eq("last.sent", 64'(sent), 64'd128);
    repeat (3) @(posedge clk);
    #1;
    check_status(0, "last", 128, 8, 0, 1, 1'b1, 1'b0);

    // rdy_en gating latency, then random backpressure.
    rdy_en_a[0] = 1'b0;
    reset_ch(0, 2, "rand.rst");
    repeat (3) @(posedge clk);
    #1;
    chk_eq("lat.rdy_off", 64'(rdy_a[0]), 64'd0);
    rdy_en_a[0] = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("lat.rdy_on", 64'(rdy_a[0]), 64'd1);
    run_stream(0, 64, 1000, -1, -1, 1'b0, 1'b1, 1'b0, sent, fd);
    chk_eq("rand.sent", 64'(sent), 64'd64);
    check_status(0, "rand", 64, 4, 0, 0, 1'b0, 1'b0);

    // Reset pulse in the middle of frame 2, then resume.
    reset_ch(0, 2, "mid.rst0");
    run_stream(0, 40, 200, -1, -1, 1'b0, 1'b0, 1'b0, sent, fd);
    check_status(0, "mid.pre", 40, 2, 0, 0, 1'b0, 1'b0);
    reset_ch(0, 1, "mid.rst1");
    run_stream(0, 16, 200, -1, -1, 1'b0, 1'b0, 1'b0, sent, fd);
    chk_eq("mid.first_beat", fd, SEED_STEP1);
    check_status(0, "mid.post", 16, 1, 0, 0, 1'b0, 1'b0);

    // Stop-on-error instance halts after the flipped beat 5.
    reset_ch(1, 2, "halt.rst");
    run_stream(1, 128, 60, 5, -1, 1'b0, 1'b0, 1'b1, sent, fd);
    chk_eq("halt.sent", 64'(sent), 64'd6);
    repeat (2) @(posedge clk);
    #1;
    check_status(1, "halt", 6, 0, 1, 0, 1'b1, 1'b0);
    chk_eq("halt.rdy", 64'(rdy_a[1]), 64'd0);

    // 4-bit counters with an error on every beat saturate at 15.
    reset_ch(2, 2, "sat.rst");
    run_stream(2, 32, 200, -1, -1, 1'b1, 1'b0, 1'b0, sent, fd);
    chk_eq("sat.sent", 64'(sent), 64'd32);
    repeat (2) @(posedge clk);
    #1;
    check_status(2, "sat", 15, 2, 15, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
